// File: rtl/idct_pkg.sv
`default_nettype none
// ============================================================================
// Module   : idct_pkg
// Purpose  : Shared constants and types for the 8x8 IDCT front end.
//            Holds the coefficient width, the coefficient type, the JPEG
//            zig-zag scan table (scan position -> raster index) and the
//            latency of the downstream IDCT core.
// Revision : 1.0 - initial release
// ============================================================================
package idct_pkg;

  localparam int COEF_WIDTH   = 16;
  localparam int IDCT_LATENCY = 29;

  typedef logic signed [15:0] coef_t;

  // Entry i is the raster position (row*8 + col) of the i-th zig-zag beat.
  localparam int ZIGZAG [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  // Raster write address for a given zig-zag beat index.
  function automatic logic [5:0] zigzag_addr(input logic [5:0] idx);
    return 6'(ZIGZAG[idx]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/idct_coef_bank.sv
`default_nettype none
// ============================================================================
// Module   : idct_coef_bank
// Purpose  : 64-word coefficient register file. One write port, every word
//            visible in parallel on rd_data. Asynchronously reset to zero.
// Ports    : clk, rst           - clock, async active-high reset
//            wr_en/wr_addr/wr_data - single write port
//            rd_data            - all words, rd_data[k] = word k
// Revision : 1.0 - initial release
// ============================================================================
module idct_coef_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [$clog2(DEPTH)-1:0]          wr_addr,
  input  logic [WIDTH-1:0]                  wr_data,
  output logic [DEPTH-1:0][WIDTH-1:0]       rd_data
);
  import idct_pkg::*;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0][WIDTH-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q;

endmodule
`default_nettype wire

// File: rtl/idct_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : idct_block_loader
// Purpose  : Serial zig-zag coefficient stream -> raster-order 8x8 block for
//            the IDCT core. Two banks ping-pong: one fills while the other is
//            presented on x0..x63 under a block-level valid/ready.
// Ports    : clk, rst                   - clock, async active-high reset
//            in_data/in_valid/in_ready  - coefficient stream (zig-zag order)
//            in_last                    - framing flag, checked only
//            x0..x63                    - presented block, raster order
//            blk_valid/blk_ready        - block handshake
//            err                        - sticky framing error
// Revision : 1.0 - initial release
// ============================================================================
module idct_block_loader #(
  parameter int COEF_WIDTH = 16,
  parameter int BLOCK_SIZE = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COEF_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  output logic [COEF_WIDTH-1:0] x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,
  output logic [COEF_WIDTH-1:0] x8,  x9,  x10, x11, x12, x13, x14, x15,
  output logic [COEF_WIDTH-1:0] x16, x17, x18, x19, x20, x21, x22, x23,
  output logic [COEF_WIDTH-1:0] x24, x25, x26, x27, x28, x29, x30, x31,
  output logic [COEF_WIDTH-1:0] x32, x33, x34, x35, x36, x37, x38, x39,
  output logic [COEF_WIDTH-1:0] x40, x41, x42, x43, x44, x45, x46, x47,
  output logic [COEF_WIDTH-1:0] x48, x49, x50, x51, x52, x53, x54, x55,
  output logic [COEF_WIDTH-1:0] x56, x57, x58, x59, x60, x61, x62, x63,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic                  err
);
  import idct_pkg::*;

  if (BLOCK_SIZE != 64) begin : g_bad_block_size
    $error("idct_block_loader: BLOCK_SIZE must be 64");
  end

  logic [5:0] idx_q,     idx_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q,    full_d;
  logic       err_q,     err_d;

  logic accept;
  logic drain;
  logic last_beat;

  logic [63:0][COEF_WIDTH-1:0] rd0;
  logic [63:0][COEF_WIDTH-1:0] rd1;
  logic [63:0][COEF_WIDTH-1:0] blk_word;

  // Gating with rst keeps the stream stalled for the whole reset pulse.
  assign in_ready  = !rst && !full_q[wr_bank_q];
  assign accept    = in_valid && in_ready;
  assign blk_valid = full_q[rd_bank_q];
  assign drain     = blk_valid && blk_ready;
  assign last_beat = (idx_q == 6'd63);
  assign err       = err_q;

  // Fill and drain can never target the same bank in one cycle: filling
  // needs the write bank empty, draining needs the read bank full.
  always_comb begin
    idx_d     = idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    err_d     = err_q;
    if (accept) begin
      if (last_beat) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        idx_d             = 6'd0;
      end else begin
        idx_d = idx_q + 6'd1;
      end
      // Block boundary is set by the count; in_last is only cross-checked.
      if (in_last != last_beat) begin
        err_d = 1'b1;
      end
    end
    if (drain) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= 6'd0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

  idct_coef_bank #(.WIDTH(COEF_WIDTH), .DEPTH(64)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && !wr_bank_q),
    .wr_addr (zigzag_addr(idx_q)),
    .wr_data (in_data),
    .rd_data (rd0)
  );

  idct_coef_bank #(.WIDTH(COEF_WIDTH), .DEPTH(64)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && wr_bank_q),
    .wr_addr (zigzag_addr(idx_q)),
    .wr_data (in_data),
    .rd_data (rd1)
  );

  assign blk_word = rd_bank_q ? rd1 : rd0;

  assign x0  = blk_word[0];  assign x1  = blk_word[1];  assign x2  = blk_word[2];  assign x3  = blk_word[3];
  assign x4  = blk_word[4];  assign x5  = blk_word[5];  assign x6  = blk_word[6];  assign x7  = blk_word[7];
  assign x8  = blk_word[8];  assign x9  = blk_word[9];  assign x10 = blk_word[10]; assign x11 = blk_word[11];
  assign x12 = blk_word[12]; assign x13 = blk_word[13]; assign x14 = blk_word[14]; assign x15 = blk_word[15];
  assign x16 = blk_word[16]; assign x17 = blk_word[17]; assign x18 = blk_word[18]; assign x19 = blk_word[19];
  assign x20 = blk_word[20]; assign x21 = blk_word[21]; assign x22 = blk_word[22]; assign x23 = blk_word[23];
  assign x24 = blk_word[24]; assign x25 = blk_word[25]; assign x26 = blk_word[26]; assign x27 = blk_word[27];
  assign x28 = blk_word[28]; assign x29 = blk_word[29]; assign x30 = blk_word[30]; assign x31 = blk_word[31];
  assign x32 = blk_word[32]; assign x33 = blk_word[33]; assign x34 = blk_word[34]; assign x35 = blk_word[35];
  assign x36 = blk_word[36]; assign x37 = blk_word[37]; assign x38 = blk_word[38]; assign x39 = blk_word[39];
  assign x40 = blk_word[40]; assign x41 = blk_word[41]; assign x42 = blk_word[42]; assign x43 = blk_word[43];
  assign x44 = blk_word[44]; assign x45 = blk_word[45]; assign x46 = blk_word[46]; assign x47 = blk_word[47];
  assign x48 = blk_word[48]; assign x49 = blk_word[49]; assign x50 = blk_word[50]; assign x51 = blk_word[51];
  assign x52 = blk_word[52]; assign x53 = blk_word[53]; assign x54 = blk_word[54]; assign x55 = blk_word[55];
  assign x56 = blk_word[56]; assign x57 = blk_word[57]; assign x58 = blk_word[58]; assign x59 = blk_word[59];
  assign x60 = blk_word[60]; assign x61 = blk_word[61]; assign x62 = blk_word[62]; assign x63 = blk_word[63];

endmodule
`default_nettype wire

// File: tb/tb_idct_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_idct_block_loader
// Purpose  : Directed self-checking bench for idct_block_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idct_block_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic        blk_valid;
  logic        blk_ready;
  logic        err;
  logic [15:0] x [64];

  int n_cmp  = 0;
  int n_mis  = 0;
  int acc_cnt = 0;

  // Raster position of each zig-zag beat (JPEG scan order).
  int zz [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  idct_block_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last),
    .x0(x[0]),   .x1(x[1]),   .x2(x[2]),   .x3(x[3]),   .x4(x[4]),   .x5(x[5]),   .x6(x[6]),   .x7(x[7]),
    .x8(x[8]),   .x9(x[9]),   .x10(x[10]), .x11(x[11]), .x12(x[12]), .x13(x[13]), .x14(x[14]), .x15(x[15]),
    .x16(x[16]), .x17(x[17]), .x18(x[18]), .x19(x[19]), .x20(x[20]), .x21(x[21]), .x22(x[22]), .x23(x[23]),
    .x24(x[24]), .x25(x[25]), .x26(x[26]), .x27(x[27]), .x28(x[28]), .x29(x[29]), .x30(x[30]), .x31(x[31]),
    .x32(x[32]), .x33(x[33]), .x34(x[34]), .x35(x[35]), .x36(x[36]), .x37(x[37]), .x38(x[38]), .x39(x[39]),
    .x40(x[40]), .x41(x[41]), .x42(x[42]), .x43(x[43]), .x44(x[44]), .x45(x[45]), .x46(x[46]), .x47(x[47]),
    .x48(x[48]), .x49(x[49]), .x50(x[50]), .x51(x[51]), .x52(x[52]), .x53(x[53]), .x54(x[54]), .x55(x[55]),
    .x56(x[56]), .x57(x[57]), .x58(x[58]), .x59(x[59]), .x60(x[60]), .x61(x[61]), .x62(x[62]), .x63(x[63]),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called and returns at a falling edge; the beat is taken at the
  // rising edge in between, once in_ready is seen high.
  task automatic send(input logic [15:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("send_timeout", 32'(t), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_blk_ready();
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
  endtask

  // Number of zig-zag positions k whose raster word differs from base+k.
  function automatic int ramp_mis(input int base);
    int m = 0;
    for (int k = 0; k < 64; k++) if (x[zz[k]] !== 16'(base + k)) m++;
    return m;
  endfunction

  function automatic int const_mis(input logic [15:0] v);
    int m = 0;
    for (int k = 0; k < 64; k++) if (x[k] !== v) m++;
    return m;
  endfunction

  initial begin
    logic [15:0] e [64];
    int m, base, early, again;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; blk_ready = 1'b0;

    // ---- reset ----
    repeat (3) @(negedge clk);
    chk("rst_blk_valid", 32'(blk_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_x_zero",    32'(const_mis(16'd0)), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ---- single block, blk_ready low ----
    send(16'd23, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'hFFFE, 1'b0);
    for (int i = 3; i < 64; i++) send(16'd0, i == 63);
    for (int k = 0; k < 64; k++) e[k] = 16'd0;
    e[0] = 16'd23; e[1] = 16'hFFFF; e[8] = 16'hFFFE;
    m = 0;
    for (int k = 0; k < 64; k++) if (x[k] !== e[k]) m++;
    chk("single_blk_valid", 32'(blk_valid), 32'd1);
    chk("single_x0", 32'(x[0]), 32'd23);
    chk("single_x1", 32'(x[1]), 32'h0000FFFF);
    chk("single_x8", 32'(x[8]), 32'h0000FFFE);
    chk("single_block", 32'(m), 32'd0);
    pulse_blk_ready();
    chk("single_drained", 32'(blk_valid), 32'd0);

    // ---- ramp, blk_ready high ----
    blk_ready = 1'b1;
    for (int i = 0; i < 64; i++) send(16'(i), i == 63);
    chk("ramp_blk_valid", 32'(blk_valid), 32'd1);
    chk("ramp_block", 32'(ramp_mis(0)), 32'd0);
    chk("ramp_x63", 32'(x[63]), 32'd63);
    chk("ramp_x56", 32'(x[56]), 32'd35);
    chk("ramp_x7",  32'(x[7]),  32'd28);
    chk("ramp_x2",  32'(x[2]),  32'd5);
    @(negedge clk);
    blk_ready = 1'b0;
    chk("ramp_drained", 32'(blk_valid), 32'd0);
    chk("ramp_no_err",  32'(err), 32'd0);

    // ---- backpressure: three blocks, blk_ready low ----
    base = acc_cnt;
    fork
      begin
        for (int b = 0; b < 3; b++)
          for (int i = 0; i < 64; i++) send(16'(32'h1000 * (b + 1) + i), i == 63);
      end
      begin
        int t = 0;
        @(negedge clk);
        while (in_ready && t < 400) begin
          @(negedge clk);
          t++;
        end
        chk("bp_drop_after_128", 32'(acc_cnt - base), 32'd128);
        chk("bp_valid", 32'(blk_valid), 32'd1);
        chk("bp_blk1", 32'(ramp_mis(32'h1000)), 32'd0);
        repeat (5) @(negedge clk);
        chk("bp_blk1_stable", 32'(ramp_mis(32'h1000)), 32'd0);
        chk("bp_still_blocked", 32'(in_ready), 32'd0);
        chk("bp_no_extra_accept", 32'(acc_cnt - base), 32'd128);
        pulse_blk_ready();
        chk("bp_blk2", 32'(ramp_mis(32'h2000)), 32'd0);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_blk2_valid", 32'(blk_valid), 32'd1);
      end
    join
    chk("bp_blk2_held", 32'(ramp_mis(32'h2000)), 32'd0);
    pulse_blk_ready();
    chk("bp_blk3_valid", 32'(blk_valid), 32'd1);
    chk("bp_blk3", 32'(ramp_mis(32'h3000)), 32'd0);
    pulse_blk_ready();
    chk("bp_all_drained", 32'(blk_valid), 32'd0);

    // ---- framing error: in_last on beat 10 ----
    for (int i = 0; i <= 10; i++) send(16'(32'h4000 + i), i == 10);
    chk("frm_err_set", 32'(err), 32'd1);
    chk("frm_not_short", 32'(blk_valid), 32'd0);
    for (int i = 11; i < 64; i++) send(16'(32'h4000 + i), i == 63);
    chk("frm_blk_valid", 32'(blk_valid), 32'd1);
    chk("frm_block", 32'(ramp_mis(32'h4000)), 32'd0);
    pulse_blk_ready();
    chk("frm_err_sticky", 32'(err), 32'd1);

    // ---- reset mid-block ----
    for (int i = 0; i < 30; i++) send(16'd7, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_err_clr", 32'(err), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_x_zero", 32'(const_mis(16'd0)), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    early = 0;
    for (int i = 0; i < 64; i++) begin
      send(16'd1, i == 63);
      if (i < 63 && blk_valid) early++;
    end
    chk("mid_rst_no_early", 32'(early), 32'd0);
    chk("mid_rst_valid", 32'(blk_valid), 32'd1);
    chk("mid_rst_ones", 32'(const_mis(16'd1)), 32'd0);
    pulse_blk_ready();
    again = 0;
    repeat (10) begin
      if (blk_valid) again++;
      @(negedge clk);
    end
    chk("mid_rst_once", 32'(again), 32'd0);
    chk("mid_rst_err_clean", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/idct_block_loader.md
# idct_block_loader

Upstream feeder for the pipelined 8x8 `IDCT` core. It accepts a serial stream of signed 16-bit coefficients in JPEG zig-zag order with a valid/ready handshake and de-zigzags them into raster order. Two coefficient banks are used as a ping-pong pair. Each completed block is presented as 64 parallel words `x0`..`x63` that wire straight onto the `IDCT` `x*` inputs, with a block-level valid/ready so a downstream controller can pace it.

## Interface
Parameters:
- `COEF_WIDTH`, default 16: coefficient width, signed two's complement.
- `BLOCK_SIZE`, default 64: coefficients per block. Fixed at 64; any other value is a compile-time error.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  COEF_WIDTH  coefficient, zig-zag order.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a beat.
- `in_last`  in  1  framing flag, expected on beat 63 of each block.
- `x0`..`x63`  out  COEF_WIDTH each  raster-order block (`xk` = row k/8, column k%8).
- `blk_valid`  out  1  `x*` holds a complete block.
- `blk_ready`  in  1  downstream has taken the presented block.
- `err`  out  1  sticky framing error.

## Operation
- State: `idx` (6-bit beat counter), `wr_bank`, `rd_bank` (1 bit each), `full[1:0]`, `err`, and two banks of 64 x COEF_WIDTH registers.
- `in_ready = !full[wr_bank]`.
- Accept = `in_valid && in_ready`.
- On each accept:
  - Write `bank[wr_bank][ZIGZAG[idx]] <= in_data`.
  - If `idx == 63`: set `full[wr_bank]`, toggle `wr_bank`, and set `idx <= 0`. Otherwise increment `idx`.
- Framing check on each accept: if `in_last != (idx == 63)`, set `err <= 1`.
- Framing is by count only. `in_last` never shortens or extends a block.
- `blk_valid = full[rd_bank]`.
- `x*` = `bank[rd_bank]`, read combinationally from the registers.
- On `blk_valid && blk_ready`: clear `full[rd_bank]` and toggle `rd_bank`.
- Filling one bank and draining the other in the same cycle are independent, and both take effect.
- With both banks full, `in_ready` stays 0 until a drain occurs. Data is never lost and the counter never advances without an accept.
- `x*` is meaningful only while `blk_valid` is 1. While it is 0, `x*` shows the stale contents of `bank[rd_bank]`.
- `x*` is stable for as long as `blk_valid` is 1 and `blk_ready` is 0. The `IDCT` core is free-running, so it recomputes the same block every cycle during that time.

## Timing
- Reset values (asserted asynchronously):
  - `idx` = 0, `wr_bank` = 0, `rd_bank` = 0, `full` = 00, `err` = 0.
  - All bank words = 0, so every `x*` output is 0.
  - `blk_valid` = 0.
- `in_ready` is driven 0 while `rst` is high. It goes to 1 in the first cycle after `rst` deasserts.
- Latency: if beat 63 is accepted at edge N, `blk_valid` = 1 and `x*` are valid in the cycle following edge N (1 cycle).
- Drain at edge M:
  - `blk_valid` reflects the other bank in the cycle after M.
  - `in_ready` rises in the cycle after M if it was blocked.
- Throughput: one coefficient per cycle sustained, i.e. one block per 64 cycles, provided `blk_ready` is held at 1.
- Reset mid-block discards the partial block and both banks, and clears `err`.
- `in_data`, `in_last` and `blk_ready` are ignored when their qualifying handshake is not active.

## Structure
- Shared package `idct_pkg` holds:
  - `COEF_WIDTH`.
  - typedef `coef_t` (logic signed [15:0]).
  - `localparam ZIGZAG[64]` = 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- The downstream `IDCT` latency constant is 29 and is also in `idct_pkg`.
- Sub-module `idct_coef_bank` (64-word register file: one write port, 64 parallel read outputs, async reset to 0) is instantiated twice. Control logic stays in the top level.

## Test plan
- Reset:
  - Hold `rst` high for 3 cycles → all `x*` = 0, `blk_valid` = 0, `in_ready` = 0, `err` = 0.
  - After release, `in_ready` = 1.
- Single block, `blk_ready` = 0:
  - Stream 23, −1, −2 followed by 61 zeros, with `in_last` on beat 63.
  - In the next cycle: `blk_valid` = 1, `x0` = 23, `x1` = −1, `x8` = −2, all other `x*` = 0.
  - Pulse `blk_ready` → `blk_valid` = 0 in the following cycle.
- Ramp, with `blk_ready` = 1:
  - Beat i carries value i.
  - Expect `x[ZIGZAG[i]]` = i, e.g. `x63` = 63, `x56` = 35, `x7` = 28, `x2` = 5.
- Backpressure:
  - Set `blk_ready` = 0 and offer 3 blocks back-to-back.
  - `in_ready` drops after beat 127 is accepted. Block 1 stays presented unchanged.
  - One-cycle `blk_ready` → block 2 presented and `in_ready` = 1 in the next cycle. Block 3 then completes.
- Framing error:
  - Assert `in_last` on beat 10 → `err` = 1 from the next cycle and remains 1.
  - The block still completes after beat 63.
  - Only `rst` clears `err`.
- Reset mid-block:
  - Accept 30 beats of 7s, then pulse `rst`, then stream a full block of 1s.
  - Presented block is all 1s, and `blk_valid` appears exactly once.
